// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_unit
//  Purpose  : Minisys-1A system control coprocessor. Holds BadVAddr, Count,
//             Compare, Status, Cause and EPC, serves mfc0/mtc0, performs the
//             hardware side of exception entry / eret and raises the gated
//             interrupt request. State changes on the falling clock edge.
//  Options  : CP0_TIMER_EN - builds the Count/Compare timer (off by default).
//  Revision : 1.0 - initial release
// ============================================================================
module cp0_unit #(
  parameter int          NUM_HW_IRQ = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_F000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            cp0_addr,
  input  logic                  cp0_wen,
  input  logic [31:0]           cp0_wdata,
  output logic [31:0]           cp0_rdata,
  input  logic [NUM_HW_IRQ-1:0] hw_irq,
  input  logic                  exc_req,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  output logic                  int_req,
  output logic [31:0]           exc_target,
  output logic [31:0]           status_out,
  output logic [31:0]           cause_out,
  output logic [31:0]           epc_out
);

  localparam logic [4:0]  c_ADDR_BADVADDR = 5'd8;
  localparam logic [4:0]  c_ADDR_COUNT    = 5'd9;
  localparam logic [4:0]  c_ADDR_COMPARE  = 5'd11;
  localparam logic [4:0]  c_ADDR_STATUS   = 5'd12;
  localparam logic [4:0]  c_ADDR_CAUSE    = 5'd13;
  localparam logic [4:0]  c_ADDR_EPC      = 5'd14;
  localparam logic [31:0] c_STATUS_MASK   = 32'h0000_FF1F;
  localparam logic [31:0] c_STATUS_RESET  = 32'h0000_FC01;

  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic        r_bd;
  logic [4:0]  r_exccode;
  logic [1:0]  r_ip_sw;
  logic [5:0]  w_ip_hw;
  logic        w_ti;
  logic [31:0] w_count_rd;
  logic [31:0] w_compare_rd;
  logic [7:0]  w_ip;
  logic [31:0] w_cause;
  logic        w_exl;
  logic        w_mtc0;

  assign w_exl  = r_status[1];
  // An mtc0 only lands when neither exception entry nor eret claims the cycle.
  assign w_mtc0 = cp0_wen & ~exc_req & ~eret;

  // Sample each implemented external interrupt line into its Cause.IP bit.
  for (genvar i = 0; i < 6; i++) begin : g_ip
    if (i < NUM_HW_IRQ) begin : g_used
      logic r_q;
      always_ff @(negedge clock) begin
        if (!reset) r_q <= 1'b0;
        else        r_q <= hw_irq[i];
      end
      assign w_ip_hw[i] = r_q;
    end else begin : g_unused
      assign w_ip_hw[i] = 1'b0;
    end
  end

  // Software-visible register state: exception entry beats eret beats mtc0.
  always_ff @(negedge clock) begin
    if (!reset) begin
      r_status   <= c_STATUS_RESET;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_bd       <= 1'b0;
      r_exccode  <= '0;
      r_ip_sw    <= '0;
    end else if (exc_req) begin
      // A nested exception (EXL already set) must not clobber the return PC.
      if (!w_exl) begin
        r_epc <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
        r_bd  <= exc_bd;
      end
      r_exccode   <= exc_code;
      r_status[1] <= 1'b1;
      if (exc_code == 5'd4 || exc_code == 5'd5) r_badvaddr <= exc_badvaddr;
    end else if (eret) begin
      r_status[1] <= 1'b0;
    end else if (cp0_wen) begin
      case (cp0_addr)
        c_ADDR_STATUS: r_status <= cp0_wdata & c_STATUS_MASK;
        c_ADDR_CAUSE:  r_ip_sw  <= cp0_wdata[9:8];
        c_ADDR_EPC:    r_epc    <= cp0_wdata;
        default:       ;
      endcase
    end
  end

`ifdef CP0_TIMER_EN
  localparam int c_PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [c_PW-1:0] r_presc;
  logic [31:0]     r_count;
  logic [31:0]     r_compare;
  logic            r_ti;
  logic            w_tick;
  logic [31:0]     w_count_inc;
  logic            w_wr_count;
  logic            w_wr_compare;

  assign w_tick       = (r_presc == c_PW'(COUNT_DIV - 1));
  assign w_count_inc  = r_count + 32'd1;
  assign w_wr_count   = w_mtc0 & (cp0_addr == c_ADDR_COUNT);
  assign w_wr_compare = w_mtc0 & (cp0_addr == c_ADDR_COMPARE);

  // Prescaled Count with a sticky Compare match; a Compare write acknowledges it.
  always_ff @(negedge clock) begin
    if (!reset) begin
      r_presc   <= '0;
      r_count   <= '0;
      r_compare <= 32'hFFFF_FFFF;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= cp0_wdata;
        r_presc <= '0;
      end else if (w_tick) begin
        r_count <= w_count_inc;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (w_wr_compare) r_compare <= cp0_wdata;
      if (w_wr_compare)
        r_ti <= 1'b0;
      else if (!w_wr_count && w_tick && (w_count_inc == r_compare))
        r_ti <= 1'b1;
    end
  end

  assign w_ti         = r_ti;
  assign w_count_rd   = r_count;
  assign w_compare_rd = r_compare;
`else
  assign w_ti         = 1'b0;
  assign w_count_rd   = '0;
  assign w_compare_rd = '0;
`endif

  // IP[7] is shared by external line 5 and the timer match.
  assign w_ip    = {w_ip_hw[5] | w_ti, w_ip_hw[4:0], r_ip_sw};
  assign w_cause = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'b00};

  assign int_req    = (|(w_ip & r_status[15:8])) & r_status[0] & ~w_exl;
  assign status_out = r_status;
  assign cause_out  = w_cause;
  assign epc_out    = r_epc;

  // mfc0 read multiplexer; unmapped addresses read zero.
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      c_ADDR_BADVADDR: cp0_rdata = r_badvaddr;
      c_ADDR_COUNT:    cp0_rdata = w_count_rd;
      c_ADDR_COMPARE:  cp0_rdata = w_compare_rd;
      c_ADDR_STATUS:   cp0_rdata = r_status;
      c_ADDR_CAUSE:    cp0_rdata = w_cause;
      c_ADDR_EPC:      cp0_rdata = r_epc;
      default:         cp0_rdata = '0;
    endcase
  end

  // Redirect target for the pipeline, valid in the same cycle as its strobe.
  always_comb begin
    exc_target = '0;
    if (exc_req)   exc_target = EXC_VECTOR;
    else if (eret) exc_target = r_epc;
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp0_unit
//  Purpose  : Directed self-checking bench for cp0_unit. Expected values are
//             queued as stimulus is driven and popped when the DUT responds.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;

  logic        clock = 1'b1;
  logic        reset;
  logic [4:0]  cp0_addr;
  logic        cp0_wen;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [5:0]  hw_irq;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic        int_req;
  logic [31:0] exc_target;
  logic [31:0] status_out;
  logic [31:0] cause_out;
  logic [31:0] epc_out;

  int n_tests = 0;
  int n_fail  = 0;

  string       sb_tag[$];
  logic [31:0] sb_exp[$];

  cp0_unit #(
    .NUM_HW_IRQ(6),
    .COUNT_DIV (2),
    .EXC_VECTOR(32'h0000_F000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cp0_addr    (cp0_addr),
    .cp0_wen     (cp0_wen),
    .cp0_wdata   (cp0_wdata),
    .cp0_rdata   (cp0_rdata),
    .hw_irq      (hw_irq),
    .exc_req     (exc_req),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .exc_bd      (exc_bd),
    .exc_badvaddr(exc_badvaddr),
    .eret        (eret),
    .int_req     (int_req),
    .exc_target  (exc_target),
    .status_out  (status_out),
    .cause_out   (cause_out),
    .epc_out     (epc_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] e);
    sb_tag.push_back(tag);
    sb_exp.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_tests++;
    if (sb_tag.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %h expected queued value", obs);
    end else begin
      t = sb_tag.pop_front();
      e = sb_exp.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", t, obs, e);
      end
    end
  endtask

  // Active edge is the falling edge; observe 1 ns after it.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] e);
    cp0_addr = a;
    push(tag, e);
    #1;
    chk(cp0_rdata);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_addr  = a;
    cp0_wdata = d;
    cp0_wen   = 1'b1;
    tick();
    cp0_wen   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cp0_addr = '0; cp0_wen = 1'b0; cp0_wdata = '0; hw_irq = '0;
    exc_req = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_badvaddr = '0; eret = 1'b0;

    // Reset state
    tick(); tick();
    rd(5'd12, "rst_status", 32'h0000_FC01);
    rd(5'd13, "rst_cause",  32'h0000_0000);
    rd(5'd14, "rst_epc",    32'h0000_0000);
    rd(5'd8,  "rst_badva",  32'h0000_0000);
    push("rst_int_req", 32'd0);    chk({31'd0, int_req});
    push("rst_exc_target", 32'd0); chk(exc_target);
    tick();
    rd(5'd9, "rst_count", 32'h0);
`ifdef CP0_TIMER_EN
    rd(5'd11, "rst_compare", 32'hFFFF_FFFF);
`else
    rd(5'd11, "rst_compare", 32'h0);
`endif
    reset = 1'b1;

    // External interrupt with reset defaults
    hw_irq = 6'h01;
    push("irq_before_edge", 32'd0); #1 chk({31'd0, int_req});
    push("irq_after_edge", 32'd1);
    tick(); chk({31'd0, int_req});
    rd(5'd13, "irq_cause", 32'h0000_0400);
    push("irq_masked", 32'd0);
    mtc0(5'd12, 32'h0000_FC00); chk({31'd0, int_req});
    rd(5'd12, "status_ie0", 32'h0000_FC00);
    hw_irq = 6'h00;
    mtc0(5'd12, 32'h0000_FC01);
    push("irq_released", 32'd0); chk({31'd0, int_req});

    // Status write mask, software interrupt bits
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, "status_mask", 32'h0000_FF1F);
    mtc0(5'd12, 32'h0000_FC01);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, "cause_sw_only", 32'h0000_0300);
    push("sw_irq_im_off", 32'd0); chk({31'd0, int_req});
    push("sw_irq_im_on", 32'd1);
    mtc0(5'd12, 32'h0000_0301); chk({31'd0, int_req});
    push("sw_irq_cleared", 32'd0);
    mtc0(5'd13, 32'h0); chk({31'd0, int_req});
    mtc0(5'd12, 32'h0000_FC01);

    // Exception in a delay slot, then a nested exception
    exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h100; exc_bd = 1'b1; exc_badvaddr = 32'hDEAD;
    push("exc_target_vec", 32'h0000_F000); #1 chk(exc_target);
    push("exc_epc", 32'h0000_00FC);
    push("exc_cause", 32'h8000_0020);
    push("exc_status", 32'h0000_FC03);
    tick(); exc_req = 1'b0;
    chk(epc_out); chk(cause_out); chk(status_out);
    rd(5'd8, "exc_badva_kept", 32'h0);
    push("exc_target_idle", 32'h0); chk(exc_target);
    exc_req = 1'b1; exc_code = 5'd12; exc_pc = 32'h200; exc_bd = 1'b0;
    push("nested_epc", 32'h0000_00FC);
    push("nested_cause", 32'h8000_0030);
    tick(); exc_req = 1'b0;
    chk(epc_out); chk(cause_out);
    eret = 1'b1;
    push("eret_target", 32'h0000_00FC); #1 chk(exc_target);
    push("eret_status", 32'h0000_FC01);
    tick(); eret = 1'b0; chk(status_out);

    // Exception + eret + mtc0 in one cycle
    exc_req = 1'b1; exc_code = 5'd10; exc_pc = 32'h300; exc_bd = 1'b0;
    eret = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h5555; cp0_wen = 1'b1;
    push("prio_target", 32'h0000_F000); #1 chk(exc_target);
    push("prio_epc", 32'h0000_0300);
    push("prio_status", 32'h0000_FC03);
    push("prio_cause", 32'h0000_0028);
    tick(); exc_req = 1'b0; eret = 1'b0; cp0_wen = 1'b0;
    chk(epc_out); chk(status_out); chk(cause_out);
    eret = 1'b1;
    push("eret2_target", 32'h0000_0300); #1 chk(exc_target);
    push("eret2_status", 32'h0000_FC01);
    tick(); eret = 1'b0; chk(status_out);
    push("mtc0_epc", 32'h0000_1234);
    mtc0(5'd14, 32'h1234); chk(epc_out);
    eret = 1'b1;
    push("eret_over_mtc0", 32'h0000_FC01);
    mtc0(5'd12, 32'h0); eret = 1'b0; chk(status_out);

    // Address error latches BadVAddr; BadVAddr and unmapped writes ignored
    exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h400; exc_bd = 1'b0; exc_badvaddr = 32'h1003;
    tick(); exc_req = 1'b0;
    rd(5'd8, "adel_badva", 32'h0000_1003);
    push("adel_epc", 32'h0000_0400); chk(epc_out);
    push("adel_cause", 32'h0000_0010); chk(cause_out);
    eret = 1'b1; tick(); eret = 1'b0;
    mtc0(5'd8, 32'hFFFF);
    rd(5'd8, "badva_ro", 32'h0000_1003);
    mtc0(5'd20, 32'hFFFF);
    rd(5'd20, "unmapped_rd", 32'h0);

    // EXL gates the interrupt request
    hw_irq = 6'h01;
    push("exl_irq_on", 32'd1); tick(); chk({31'd0, int_req});
    exc_req = 1'b1; exc_code = 5'd0; exc_pc = 32'h500;
    push("exl_gate", 32'd0); tick(); exc_req = 1'b0; chk({31'd0, int_req});
    push("exl_epc", 32'h0000_0500); chk(epc_out);
    eret = 1'b1;
    push("exl_ungate", 32'd1); tick(); eret = 1'b0; chk({31'd0, int_req});
    hw_irq = 6'h00; tick();

    // hw_irq[5] lands on IP[7]
    hw_irq = 6'h20;
    push("irq5_cause", 32'h0000_8000);
    push("irq5_int_req", 32'd1);
    tick(); chk(cause_out); chk({31'd0, int_req});
    hw_irq = 6'h00; tick();

    // Reset wins over a simultaneous exception
    reset = 1'b0; exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h700;
    push("rstprio_epc", 32'h0);
    push("rstprio_status", 32'h0000_FC01);
    push("rstprio_cause", 32'h0);
    tick(); exc_req = 1'b0;
    chk(epc_out); chk(status_out); chk(cause_out);
    reset = 1'b1;

`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    push("timer_early", 32'h0);
    repeat (9) tick();
    chk(cause_out);
    rd(5'd9, "timer_count4", 32'd4);
    push("timer_match_cause", 32'h4000_8000);
    push("timer_int_req", 32'd1);
    tick(); chk(cause_out); chk({31'd0, int_req});
    rd(5'd9, "timer_count5", 32'd5);
    push("timer_ack_cause", 32'h0);
    push("timer_ack_int", 32'd0);
    mtc0(5'd11, 32'd100); chk(cause_out); chk({31'd0, int_req});
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, "count_max", 32'hFFFF_FFFF);
    tick(); tick();
    rd(5'd9, "count_wrap", 32'h0);
`else
    mtc0(5'd9, 32'd123);
    rd(5'd9, "notimer_count", 32'h0);
    mtc0(5'd11, 32'd5);
    rd(5'd11, "notimer_compare", 32'h0);
    repeat (12) tick();
    push("notimer_ti", 32'h0); chk(cause_out);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cp0_unit.md
# cp0_unit

Parametrised System Control Coprocessor (CP0) for the Minisys-1A CPU. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and serves `mfc0`/`mtc0` accesses. It also performs the hardware side of exception entry and `eret` atomically, and samples external interrupt lines. It raises a gated interrupt request to the pipeline control and runs an optional Count/Compare timer.

## Interface
Parameters:
- `NUM_HW_IRQ`, 6: external interrupt lines, range 1–6. They map to Cause.IP[2+i]; unused IP bits read 0.
- `COUNT_DIV`, 2: clock cycles per Count increment, ≥1.
- `EXC_VECTOR`, 32'h0000_F000: handler entry address driven on `exc_target` during exception entry.

Ports (one clock; reset is synchronous and active-low):
- `clock`  in  1  — system clock. All state updates on the falling edge.
- `reset`  in  1  — synchronous, active-low reset, sampled on the falling edge of `clock`.
- `cp0_addr`  in  5  — CP0 register number (rd field) for `mfc0`/`mtc0`.
- `cp0_wen`  in  1  — `mtc0` write strobe.
- `cp0_wdata`  in  32  — `mtc0` data.
- `cp0_rdata`  out  32  — `mfc0` read data, combinational from `cp0_addr`.
- `hw_irq`  in  NUM_HW_IRQ  — level-sensitive external interrupts.
- `exc_req`  in  1  — exception commit strobe, one cycle.
- `exc_code`  in  5  — ExcCode of the committing exception.
- `exc_pc`  in  32  — PC of the faulting instruction.
- `exc_bd`  in  1  — faulting instruction is in a branch delay slot.
- `exc_badvaddr`  in  32  — faulting address for AdEL/AdES.
- `eret`  in  1  — `eret` commit strobe, one cycle.
- `int_req`  out  1  — pending, enabled interrupt.
- `exc_target`  out  32  — `EXC_VECTOR` when `exc_req`, EPC when `eret`, otherwise 0. Combinational.
- `status_out`, `cause_out`, `epc_out`  out  32 each  — live register values.

## Operation
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Other addresses read 0 and ignore writes.
- Status field layout: IM = [15:8], EXL = [1], IE = [0].
- Status write mask: bits [15:8] and [4:0]. All other bits read 0.
- Cause field layout: BD = [31], TI = [30], IP = [15:8], ExcCode = [6:2].
- Cause writes by `mtc0` affect only IP[1:0] (software interrupts). All other Cause bits are hardware-owned.
- BadVAddr is read-only to software.
- Interrupt sampling: every edge, Cause.IP[2+i] ← `hw_irq[i]`. IP[7] ← IP[7] | timer match, combined with `hw_irq[5]` by OR.
- `int_req` = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL.
- Exception entry, when `exc_req` = 1:
  - If EXL = 0: EPC ← `exc_bd` ? `exc_pc` − 4 : `exc_pc`, and BD ← `exc_bd`.
  - If EXL = 1: EPC and BD are unchanged.
  - In both cases: ExcCode ← `exc_code`, EXL ← 1.
  - If `exc_code` is 4 or 5: BadVAddr ← `exc_badvaddr`.
- `eret`: EXL ← 0. EPC is unchanged.
- Priority in one cycle: `exc_req` > `eret` > `mtc0`. The lower-priority request is dropped entirely.
- An `mtc0` to Status coinciding with an IP update applies both; they touch disjoint bits.
- Timer:
  - A prescaler counts 0..COUNT_DIV−1. On wrap, Count ← Count + 1, mod 2^32; 0xFFFF_FFFF wraps to 0.
  - When the incremented Count equals Compare, TI and IP[7] are set sticky.
  - `mtc0` to Compare clears TI and IP[7], unless `hw_irq[5]` is high, in which case IP[7] stays set.
  - `mtc0` to Count loads Count and clears the prescaler.

## Timing
- Reset values: Status = 32'h0000_FC01 (IM[7:2] = 1, IE = 1), Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 32'hFFFF_FFFF, prescaler = 0.
- Reset output values: `int_req` = 0, `cp0_rdata` = the selected reset value, `exc_target` = 0 when no strobe is asserted.
- Reset has priority over every other input. A reset asserted during the same edge as `exc_req` leaves reset values.
- Write latency: an `mtc0`, exception or `eret` takes effect on the falling edge of its cycle. The new value is visible on `cp0_rdata` and `*_out` before the next rising edge.
- `hw_irq` to `int_req`: one falling edge.
- `exc_target` is valid in the same cycle as its strobe, with zero latency.

## Configuration
- `CP0_TIMER_EN` defined: Count, Compare, prescaler and timer interrupt are implemented as described.
- `CP0_TIMER_EN` undefined:
  - Addresses 9 and 11 read 0 and ignore writes.
  - TI reads 0, and IP[7] follows `hw_irq[5]` only.
  - No timer flops are synthesised.

## Test plan
- Reset release: `cp0_rdata` at addresses 12/13/14 = 0000_FC01 / 0000_0000 / 0000_0000; `int_req` = 0.
- `hw_irq[0]` = 1 with reset defaults: `int_req` = 1 after one falling edge. After `mtc0` Status = 0000_FC00, `int_req` = 0.
- `exc_req`, `exc_code` = 8, `exc_pc` = 0x100, `exc_bd` = 1: EPC = 0xFC, Cause = 0x8000_0020, EXL = 1, `exc_target` = 0xF000. A second `exc_req` leaves EPC = 0xFC.
- `exc_req` together with `mtc0` EPC = 0x5555 and `eret`: EPC from the exception, EXL = 1. A following `eret`: EXL = 0, `exc_target` = EPC.
- Timer with COUNT_DIV = 2, Compare = 5, Count = 0: TI/IP[7] set after 10 cycles. Writing Compare clears them. Count 0xFFFF_FFFF wraps to 0.
- AdEL (`exc_code` = 4), `exc_badvaddr` = 0x1003: BadVAddr = 0x1003. An `mtc0` to address 8 is ignored.
